// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, opcodes and the fetch FSM encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_HALT  = 6'h3F
  } opcode_t;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t RUN    = 1'b0;
  localparam fetch_state_t HALTED = 1'b1;

  // sll $0,$0,0 encodes as all zeros, so a bubble is a real NOP
  localparam word_t NOP_INSTR = 32'h0000_0000;

  function automatic word_t pc_plus4(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_latch.sv
// IF/ID pipeline register: hold beats bubble, bubble beats load.
module if_id_latch
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  bubble,
  input  word_t load_instr,
  input  word_t load_npc,
  output word_t instr,
  output word_t npc,
  output logic  valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= NOP_INSTR;
      npc   <= '0;
      valid <= 1'b0;
    end else if (hold) begin
      instr <= instr;
      npc   <= npc;
      valid <= valid;
    end else if (bubble) begin
      instr <= NOP_INSTR;
      npc   <= '0;
      valid <= 1'b0;
    end else begin
      instr <= load_instr;
      npc   <= load_npc;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, icache request, run/halt FSM and IF/ID latch.
// Optional FETCH_PERF_COUNTERS_EN adds stall_cycles / flush_count outputs.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        dmem_stall,
  input  logic        hazard,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic [31:0] id_instr,
  output logic [31:0] id_npc,
  output logic        id_valid,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic        halted
);

  fetch_state_t state, state_next;
  word_t        pc, pc_next, pc_inc;
  logic         run, hold, bubble;
  logic         stall_evt, flush_evt;

  assign run      = (state == RUN);
  assign pc_inc   = pc_plus4(pc);
  assign imemREN  = run;
  assign imemaddr = pc;
  assign halted   = (state == HALTED);

  // Priority chain; branch/jump under hazard are dropped because the
  // hazard unit keeps re-presenting an unresolved branch.
  always_comb begin
    pc_next    = pc;
    state_next = state;
    hold       = 1'b0;
    bubble     = 1'b0;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;
    if (run) begin
      if (dmem_stall) begin
        hold      = 1'b1;
        stall_evt = 1'b1;
      end else if (halt) begin
        bubble     = 1'b1;
        state_next = HALTED;
      end else if (hazard) begin
        hold      = 1'b1;
        stall_evt = 1'b1;
      end else if (jump) begin
        pc_next   = jump_target;
        bubble    = 1'b1;
        flush_evt = 1'b1;
      end else if (branch) begin
        pc_next   = branch_target;
        bubble    = 1'b1;
        flush_evt = 1'b1;
      end else if (ihit) begin
        pc_next = pc_inc;
      end else begin
        bubble    = 1'b1;
        stall_evt = 1'b1;
      end
    end else begin
      hold = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc    <= PC_INIT;
      state <= RUN;
    end else begin
      pc    <= pc_next;
      state <= state_next;
    end
  end

  if_id_latch u_if_id (
    .clk        (CLK),
    .rst        (RST),
    .hold       (hold),
    .bubble     (bubble),
    .load_instr (imemload),
    .load_npc   (pc_inc),
    .instr      (id_instr),
    .npc        (id_npc),
    .valid      (id_valid)
  );

`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_evt && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
      if (flush_evt && flush_count != 32'hFFFF_FFFF)  flush_count  <= flush_count + 32'd1;
    end
  end
`else
  logic unused_evt;
  assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table, corner sequences,
// and randomized traffic against a per-cycle behavioural model.
module tb_fetch_stage;
  localparam logic [31:0] PCI = 32'h0000_0100;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        ihit = 0, imemREN, dmem_stall = 0, hazard = 0, branch = 0, jump = 0, halt = 0;
  logic [31:0] imemload = 0, imemaddr, branch_target = 0, jump_target = 0;
  logic [31:0] id_instr, id_npc;
  logic        id_valid, halted;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int checks = 0, failures = 0;

  fetch_stage #(.PC_INIT(PCI)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
    .imemaddr(imemaddr), .dmem_stall(dmem_stall), .hazard(hazard), .branch(branch),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target), .halt(halt),
    .id_instr(id_instr), .id_npc(id_npc), .id_valid(id_valid),
`ifdef FETCH_PERF_COUNTERS_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .halted(halted));

  always #5 CLK = ~CLK;

  // Behavioural model: architectural state stepped once per clock.
  logic [31:0] m_pc, m_instr, m_npc, m_stall, m_flush;
  logic        m_valid, m_halted;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic m_reset();
    m_pc = PCI; m_instr = 0; m_npc = 0; m_valid = 0; m_halted = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic m_bubble();
    m_instr = 0; m_npc = 0; m_valid = 0;
  endtask

  task automatic m_step();
    if (m_halted) return;
    if (dmem_stall) m_stall = sat_inc(m_stall);
    else if (halt) begin m_bubble(); m_halted = 1; end
    else if (hazard) m_stall = sat_inc(m_stall);
    else if (jump || branch) begin
      m_pc = jump ? jump_target : branch_target; m_bubble(); m_flush = sat_inc(m_flush);
    end else if (ihit) begin
      m_instr = imemload; m_npc = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
    end else begin m_bubble(); m_stall = sat_inc(m_stall); end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".imemaddr"}, imemaddr, m_pc);
    chk({tag, ".imemREN"}, {31'b0, imemREN}, {31'b0, ~m_halted});
    chk({tag, ".id_instr"}, id_instr, m_instr);
    chk({tag, ".id_npc"}, id_npc, m_npc);
    chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, m_valid});
    chk({tag, ".halted"}, {31'b0, halted}, {31'b0, m_halted});
  endtask

  // Inputs are driven at negedge; the model steps with the DUT at posedge.
  task automatic cyc(input logic ds, h, hz, j, b, ih,
                     input logic [31:0] bt, jt, ld);
    dmem_stall = ds; halt = h; hazard = hz; jump = j; branch = b; ihit = ih;
    branch_target = bt; jump_target = jt; imemload = ld;
    @(posedge CLK); m_step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1; #1; m_reset();
    @(posedge CLK); @(negedge CLK); RST = 0;
  endtask

  typedef struct {
    logic ds, h, hz, j, b, ih;
    logic [31:0] bt, jt, ld;
    logic [31:0] e_addr, e_npc, e_instr;
    logic e_valid;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // {ds,h,hz,j,b,ih, bt,jt,ld, exp addr,npc,instr,valid}
    tbl[0]  = '{0,0,0,0,0,1, 0,0,32'hA0, 32'h104, 32'h104, 32'hA0, 1};
    tbl[1]  = '{0,0,0,0,0,1, 0,0,32'hA1, 32'h108, 32'h108, 32'hA1, 1};
    tbl[2]  = '{0,0,0,0,0,1, 0,0,32'hA2, 32'h10C, 32'h10C, 32'hA2, 1};
    tbl[3]  = '{0,0,0,0,0,1, 0,0,32'hA3, 32'h110, 32'h110, 32'hA3, 1};
    tbl[4]  = '{0,0,1,0,1,1, 32'h400,0,32'hB4, 32'h110, 32'h110, 32'hA3, 1};
    tbl[5]  = '{1,0,0,1,0,1, 0,32'h800,32'hB5, 32'h110, 32'h110, 32'hA3, 1};
    tbl[6]  = '{0,0,0,1,0,1, 0,32'h800,32'hB6, 32'h800, 0, 0, 0};
    tbl[7]  = '{0,0,0,0,1,1, 32'h400,0,32'hB7, 32'h400, 0, 0, 0};
    tbl[8]  = '{0,0,0,0,0,0, 0,0,32'hB8, 32'h400, 0, 0, 0};
    tbl[9]  = '{0,0,0,0,0,1, 0,0,32'hA9, 32'h404, 32'h404, 32'hA9, 1};
    tbl[10] = '{0,0,0,1,1,1, 32'h40,32'h20,32'hBA, 32'h20, 0, 0, 0};
    tbl[11] = '{0,0,0,0,0,0, 0,0,0, 32'h20, 0, 0, 0};
    tbl[12] = '{0,0,0,0,0,0, 0,0,0, 32'h20, 0, 0, 0};
    tbl[13] = '{0,0,0,0,0,0, 0,0,0, 32'h20, 0, 0, 0};
    tbl[14] = '{0,0,0,0,0,1, 0,0,32'hAE, 32'h24, 32'h24, 32'hAE, 1};

    // Reset state, observed while RST is still high
    m_reset();
    @(negedge CLK);
    chk("rst.imemaddr", imemaddr, PCI);
    chk("rst.imemREN", {31'b0, imemREN}, 32'd1);
    chk("rst.id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst.id_npc", id_npc, 32'd0);
    chk("rst.halted", {31'b0, halted}, 32'd0);
    RST = 0;

    for (int i = 0; i < 15; i++) begin
      chk($sformatf("tbl%0d.pre_addr", i), imemaddr, (i == 0) ? PCI : tbl[i-1].e_addr);
      cyc(tbl[i].ds, tbl[i].h, tbl[i].hz, tbl[i].j, tbl[i].b, tbl[i].ih,
          tbl[i].bt, tbl[i].jt, tbl[i].ld);
      chk($sformatf("tbl%0d.addr", i), imemaddr, tbl[i].e_addr);
      chk($sformatf("tbl%0d.npc", i), id_npc, tbl[i].e_npc);
      chk($sformatf("tbl%0d.instr", i), id_instr, tbl[i].e_instr);
      chk($sformatf("tbl%0d.valid", i), {31'b0, id_valid}, {31'b0, tbl[i].e_valid});
    end

    // halt under dmem_stall is deferred; then halt freezes everything
    cyc(1,1,0,0,0,1, 0,0,32'hC0);
    chk("halt_ds.halted", {31'b0, halted}, 32'd0);
    chk("halt_ds.valid", {31'b0, id_valid}, 32'd1);
    cyc(0,1,0,0,0,1, 0,0,32'hC1);
    chk("halt.halted", {31'b0, halted}, 32'd1);
    chk("halt.imemREN", {31'b0, imemREN}, 32'd0);
    chk("halt.addr", imemaddr, 32'h24);
    chk("halt.valid", {31'b0, id_valid}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(0,0,0,1,1,1, 32'h40,32'h80,32'hC2);
    chk("halted_hold.addr", imemaddr, 32'h24);
    chk("halted_hold.halted", {31'b0, halted}, 32'd1);
    chk("halted_hold.valid", {31'b0, id_valid}, 32'd0);

    // Asynchronous reset: effect visible before any clock edge
    #2 RST = 1; #1;
    chk("async_rst.addr", imemaddr, PCI);
    chk("async_rst.halted", {31'b0, halted}, 32'd0);
    chk("async_rst.imemREN", {31'b0, imemREN}, 32'd1);
    @(negedge CLK); RST = 0; m_reset();

    // PC wraps past 32'hFFFF_FFFC
    cyc(0,0,0,1,0,0, 0,32'hFFFF_FFFC,0);
    chk("wrap.pre", imemaddr, 32'hFFFF_FFFC);
    cyc(0,0,0,0,0,1, 0,0,32'hD0);
    chk("wrap.addr", imemaddr, 32'h0);
    chk("wrap.npc", id_npc, 32'h0);
    chk("wrap.valid", {31'b0, id_valid}, 32'd1);

`ifdef FETCH_PERF_COUNTERS_EN
    do_reset();
    chk("perf.rst_stall", stall_cycles, 0);
    cyc(0,0,0,1,0,1, 0,32'h200,0);
    cyc(0,0,1,0,0,1, 0,0,0);
    cyc(0,0,1,0,0,1, 0,0,0);
    cyc(1,0,0,0,0,1, 0,0,0);
    cyc(0,0,0,0,1,1, 32'h300,0,0);
    cyc(0,0,0,0,0,0, 0,0,0);
    cyc(0,0,0,0,0,0, 0,0,0);
    cyc(0,0,0,0,0,1, 0,0,32'h11);
    chk("perf.flush", flush_count, 32'd2);
    chk("perf.stall", stall_cycles, 32'd5);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (m_halted && $urandom_range(0, 7) == 0) do_reset();
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 60) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
          $urandom & 32'hFFFF_FFFC, $urandom, $urandom);
      chk_model($sformatf("rnd%0d", n));
`ifdef FETCH_PERF_COUNTERS_EN
      chk($sformatf("rnd%0d.stall", n), stall_cycles, m_stall);
      chk($sformatf("rnd%0d.flush", n), flush_count, m_flush);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
